control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have parameter IR_W, default 32, giving the instruction register width.
REQ-002 The block SHALL have parameter OPC_W, default 5, giving the opcode width taken from ir[IR_W-1 -: OPC_W].
REQ-003 The block SHALL have parameter WAIT_MAX, default 15, giving the maximum memory wait cycles before timeout.
REQ-004 The block SHALL have clock (input, 1), the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have clear (input, 1), the reset; reset is synchronous and active-high.
REQ-006 The block SHALL have run (input, 1), which resumes from HALT.
REQ-007 The block SHALL have mem_ready (input, 1), the memory completion handshake.
REQ-008 The block SHALL have ir (input, IR_W), the datapath IR contents.
REQ-009 The block SHALL drive datapath controls (outputs, 1 each): PCout, PCin, IncPC, MARin, MDRin, MDRout, MD_read, Read, Write, IRin, Yin, Zlowin, Zlowout, Csignout, Gra, Grb, Grc, Rin, Rout, BAout, ADD.
REQ-010 The block SHALL drive status outputs (1 each): halted, instr_done (1-cycle pulse), illegal (1-cycle pulse), mem_err (1-cycle pulse).

Function
REQ-011 The block SHALL be a Moore FSM; every control output SHALL be decoded from the present state only and held for the whole state cycle.
REQ-012 Fetch: F0 asserts PCout, MARin, IncPC, Zlowin; F1 asserts Zlowout, PCin, Read, MD_read, MDRin; F2 asserts MDRout, IRin.
REQ-013 F1 and every Read/Write state SHALL be memory states: the FSM SHALL remain in the state while mem_ready=0 and advance on the cycle mem_ready=1 is sampled.
REQ-014 PCin SHALL be asserted only on the exit cycle of F1 so PC increments exactly once per fetch.
REQ-015 In E0 the FSM SHALL decode opcode: ld=00000, ldi=00001, st=00010, add=00011, addi=01100, nop=11010, halt=11011.
REQ-016 ldi: E0 Grb, BAout, Yin; E1 Csignout, ADD, Zlowin; E2 Zlowout, Gra, Rin.
REQ-017 addi: E0 Grb, Rout, Yin; E1 Csignout, ADD, Zlowin; E2 Zlowout, Gra, Rin.
REQ-018 add: E0 Grb, Rout, Yin; E1 Grc, Rout, ADD, Zlowin; E2 Zlowout, Gra, Rin.
REQ-019 ld: E0-E1 as ldi; E2 Zlowout, MARin; E3 Read, MD_read, MDRin (memory state); E4 MDRout, Gra, Rin.
REQ-020 st: E0-E1 as ldi; E2 Zlowout, MARin; E3 Gra, Rout, MDRin; E4 MDRout, Write (memory state).
REQ-021 instr_done SHALL pulse in the last execute state of each instruction, and in E0 for nop; next state SHALL be F0.
REQ-022 halt SHALL enter HALT: all controls 0, halted=1; HALT SHALL persist until run=1, then go to F0 next cycle.
REQ-023 An undefined opcode SHALL pulse illegal in E0, assert no controls, and return to F0.
REQ-024 A wait counter SHALL count cycles in a memory state; if mem_ready is still 0 after WAIT_MAX cycles, mem_err SHALL pulse, the access SHALL be dropped, and the FSM SHALL go to F0.
REQ-025 The wait counter SHALL clear on every memory-state entry and exit.
REQ-026 Minimum latency with mem_ready tied high SHALL be: ldi/addi/add 6 cycles, ld/st 8 cycles, nop 4 cycles, counted F0 through done.

Reset
REQ-027 clear=1 SHALL, at the next edge, force state F0 and the wait counter to 0, and SHALL override run, mem_ready and ir.
REQ-028 While clear=1, all control and status outputs SHALL be 0; first F0 controls appear in the cycle after clear falls.
REQ-029 clear mid-instruction or mid-wait SHALL abort with no further Rin, PCin or Write pulses.

Verification
REQ-030 ldi, ir=32'h0880_0005, mem_ready=1 -> F0..E2 in 6 cycles; Gra/Rin/Zlowout high only in cycle 6; instr_done pulses in cycle 6.
REQ-031 ld, mem_ready low for 3 cycles in F1 and E3 -> F1 and E3 each last 4 cycles; total 14 cycles; one PCin pulse.
REQ-032 halt opcode 5'b11011 -> halted=1 from E0; run=1 for 1 cycle after 5 idle cycles -> F0 next cycle, halted=0.
REQ-033 Opcode 5'b11111 -> illegal pulses once in E0, no Rin or Write, F0 next cycle.
REQ-034 st with mem_ready=0 for 20 cycles, WAIT_MAX=15 -> mem_err pulses once at wait cycle 15; Write then drops; F0 next cycle.
REQ-035 clear=1 during E1 of add -> all outputs 0 next cycle; no Rin seen; F0 follows clear deassertion.

Source files
------------

// File: rtl/control_sequencer_if.sv
// ============================================================================
// Module      : control_sequencer_if
// Description : Bundles the sequencer's handshake inputs, IR, datapath strobes
//               and status flags between the sequencer and the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface control_sequencer_if #(
   parameter int IR_W = 32
) ();
   logic            run;
   logic            mem_ready;
   logic [IR_W-1:0] ir;

   logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MD_read, Read, Write, IRin;
   logic Yin, Zlowin, Zlowout, Csignout, Gra, Grb, Grc, Rin, Rout, BAout, ADD;

   logic halted, instr_done, illegal, mem_err;

   modport master (
      input  run, mem_ready, ir,
      output PCout, PCin, IncPC, MARin, MDRin, MDRout, MD_read, Read, Write, IRin,
      output Yin, Zlowin, Zlowout, Csignout, Gra, Grb, Grc, Rin, Rout, BAout, ADD,
      output halted, instr_done, illegal, mem_err
   );

   modport slave (
      output run, mem_ready, ir,
      input  PCout, PCin, IncPC, MARin, MDRin, MDRout, MD_read, Read, Write, IRin,
      input  Yin, Zlowin, Zlowout, Csignout, Gra, Grb, Grc, Rin, Rout, BAout, ADD,
      input  halted, instr_done, illegal, mem_err
   );
endinterface

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module      : control_sequencer
// Description : Moore fetch/execute sequencer generating datapath strobes for
//               ld/ldi/st/add/addi/nop/halt with memory wait and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
   parameter int IR_W     = 32,
   parameter int OPC_W    = 5,
   parameter int WAIT_MAX = 15
) (
   input  logic                 clock,
   input  logic                 clear,
   control_sequencer_if.master  bus
);

   typedef enum logic [3:0] {
      S_F0   = 4'd0,
      S_F1   = 4'd1,
      S_F2   = 4'd2,
      S_E0   = 4'd3,
      S_E1   = 4'd4,
      S_E2   = 4'd5,
      S_E3   = 4'd6,
      S_E4   = 4'd7,
      S_HALT = 4'd8
   } state_t;

   localparam logic [OPC_W-1:0] c_OP_LD   = OPC_W'(0);
   localparam logic [OPC_W-1:0] c_OP_LDI  = OPC_W'(1);
   localparam logic [OPC_W-1:0] c_OP_ST   = OPC_W'(2);
   localparam logic [OPC_W-1:0] c_OP_ADD  = OPC_W'(3);
   localparam logic [OPC_W-1:0] c_OP_ADDI = OPC_W'(12);
   localparam logic [OPC_W-1:0] c_OP_NOP  = OPC_W'(26);
   localparam logic [OPC_W-1:0] c_OP_HALT = OPC_W'(27);

   localparam int c_WAIT_CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
   localparam logic [c_WAIT_CW-1:0] c_WAIT_LAST = c_WAIT_CW'(WAIT_MAX - 1);

   // Bit positions inside the packed control vector, MSB first.
   localparam int c_PCOUT    = 20;
   localparam int c_PCIN     = 19;
   localparam int c_INCPC    = 18;
   localparam int c_MARIN    = 17;
   localparam int c_MDRIN    = 16;
   localparam int c_MDROUT   = 15;
   localparam int c_MDREAD   = 14;
   localparam int c_READ     = 13;
   localparam int c_WRITE    = 12;
   localparam int c_IRIN     = 11;
   localparam int c_YIN      = 10;
   localparam int c_ZLOWIN   = 9;
   localparam int c_ZLOWOUT  = 8;
   localparam int c_CSIGNOUT = 7;
   localparam int c_GRA      = 6;
   localparam int c_GRB      = 5;
   localparam int c_GRC      = 4;
   localparam int c_RIN      = 3;
   localparam int c_ROUT     = 2;
   localparam int c_BAOUT    = 1;
   localparam int c_ADD      = 0;

   state_t                 state_q, state_d;
   logic [OPC_W-1:0]       opc_q, opc_d;
   logic [c_WAIT_CW-1:0]   wait_q, wait_d;

   logic [20:0]            ctrl;
   logic                   halted, instr_done, illegal, mem_err;
   logic                   mem_state;
   logic [OPC_W-1:0]       w_opc;

   assign w_opc = bus.ir[IR_W-1 -: OPC_W];

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= S_F0;
         opc_q   <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      opc_d      = opc_q;
      wait_d     = '0;
      ctrl       = '0;
      halted     = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      mem_err    = 1'b0;
      mem_state  = 1'b0;

      case (state_q)
         S_F0: begin
            ctrl[c_PCOUT]  = 1'b1;
            ctrl[c_MARIN]  = 1'b1;
            ctrl[c_INCPC]  = 1'b1;
            ctrl[c_ZLOWIN] = 1'b1;
            state_d        = S_F1;
         end
         S_F1: begin
            mem_state       = 1'b1;
            ctrl[c_ZLOWOUT] = 1'b1;
            ctrl[c_READ]    = 1'b1;
            ctrl[c_MDREAD]  = 1'b1;
            ctrl[c_MDRIN]   = 1'b1;
            // PC is loaded only on the completing cycle so it moves once.
            if (bus.mem_ready) begin
               ctrl[c_PCIN] = 1'b1;
               state_d      = S_F2;
            end
         end
         S_F2: begin
            ctrl[c_MDROUT] = 1'b1;
            ctrl[c_IRIN]   = 1'b1;
            state_d        = S_E0;
         end
         S_E0: begin
            opc_d = w_opc;
            case (w_opc)
               c_OP_LD, c_OP_LDI, c_OP_ST: begin
                  ctrl[c_GRB]   = 1'b1;
                  ctrl[c_BAOUT] = 1'b1;
                  ctrl[c_YIN]   = 1'b1;
                  state_d       = S_E1;
               end
               c_OP_ADD, c_OP_ADDI: begin
                  ctrl[c_GRB]  = 1'b1;
                  ctrl[c_ROUT] = 1'b1;
                  ctrl[c_YIN]  = 1'b1;
                  state_d      = S_E1;
               end
               c_OP_NOP: begin
                  instr_done = 1'b1;
                  state_d    = S_F0;
               end
               c_OP_HALT: begin
                  halted  = 1'b1;
                  state_d = S_HALT;
               end
               default: begin
                  illegal = 1'b1;
                  state_d = S_F0;
               end
            endcase
         end
         S_E1: begin
            ctrl[c_ADD]    = 1'b1;
            ctrl[c_ZLOWIN] = 1'b1;
            if (opc_q == c_OP_ADD) begin
               ctrl[c_GRC]  = 1'b1;
               ctrl[c_ROUT] = 1'b1;
            end else begin
               ctrl[c_CSIGNOUT] = 1'b1;
            end
            state_d = S_E2;
         end
         S_E2: begin
            ctrl[c_ZLOWOUT] = 1'b1;
            if (opc_q == c_OP_LD || opc_q == c_OP_ST) begin
               ctrl[c_MARIN] = 1'b1;
               state_d       = S_E3;
            end else begin
               ctrl[c_GRA] = 1'b1;
               ctrl[c_RIN] = 1'b1;
               instr_done  = 1'b1;
               state_d     = S_F0;
            end
         end
         S_E3: begin
            ctrl[c_MDRIN] = 1'b1;
            if (opc_q == c_OP_LD) begin
               mem_state      = 1'b1;
               ctrl[c_READ]   = 1'b1;
               ctrl[c_MDREAD] = 1'b1;
               if (bus.mem_ready) begin
                  state_d = S_E4;
               end
            end else begin
               ctrl[c_GRA]  = 1'b1;
               ctrl[c_ROUT] = 1'b1;
               state_d      = S_E4;
            end
         end
         S_E4: begin
            ctrl[c_MDROUT] = 1'b1;
            if (opc_q == c_OP_LD) begin
               ctrl[c_GRA] = 1'b1;
               ctrl[c_RIN] = 1'b1;
               instr_done  = 1'b1;
               state_d     = S_F0;
            end else begin
               mem_state     = 1'b1;
               ctrl[c_WRITE] = 1'b1;
               if (bus.mem_ready) begin
                  instr_done = 1'b1;
                  state_d    = S_F0;
               end
            end
         end
         S_HALT: begin
            halted = 1'b1;
            if (bus.run) begin
               state_d = S_F0;
            end
         end
         default: begin
            state_d = S_F0;
         end
      endcase

      // Waiting memory state: count, or abandon the access once the budget is spent.
      if (mem_state && !bus.mem_ready) begin
         if (wait_q == c_WAIT_LAST) begin
            mem_err = 1'b1;
            state_d = S_F0;
         end else begin
            wait_d = wait_q + 1'b1;
         end
      end
   end

   assign {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout,
           bus.MD_read, bus.Read, bus.Write, bus.IRin, bus.Yin, bus.Zlowin,
           bus.Zlowout, bus.Csignout, bus.Gra, bus.Grb, bus.Grc, bus.Rin,
           bus.Rout, bus.BAout, bus.ADD} = clear ? '0 : ctrl;

   assign {bus.halted, bus.instr_done, bus.illegal, bus.mem_err} =
          clear ? 4'b0000 : {halted, instr_done, illegal, mem_err};

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed cycle-by-cycle checks of the control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

   localparam logic [20:0] c_PCOUT    = 21'h1 << 20;
   localparam logic [20:0] c_PCIN     = 21'h1 << 19;
   localparam logic [20:0] c_INCPC    = 21'h1 << 18;
   localparam logic [20:0] c_MARIN    = 21'h1 << 17;
   localparam logic [20:0] c_MDRIN    = 21'h1 << 16;
   localparam logic [20:0] c_MDROUT   = 21'h1 << 15;
   localparam logic [20:0] c_MDREAD   = 21'h1 << 14;
   localparam logic [20:0] c_READ     = 21'h1 << 13;
   localparam logic [20:0] c_WRITE    = 21'h1 << 12;
   localparam logic [20:0] c_IRIN     = 21'h1 << 11;
   localparam logic [20:0] c_YIN      = 21'h1 << 10;
   localparam logic [20:0] c_ZLOWIN   = 21'h1 << 9;
   localparam logic [20:0] c_ZLOWOUT  = 21'h1 << 8;
   localparam logic [20:0] c_CSIGN    = 21'h1 << 7;
   localparam logic [20:0] c_GRA      = 21'h1 << 6;
   localparam logic [20:0] c_GRB      = 21'h1 << 5;
   localparam logic [20:0] c_GRC      = 21'h1 << 4;
   localparam logic [20:0] c_RIN      = 21'h1 << 3;
   localparam logic [20:0] c_ROUT     = 21'h1 << 2;
   localparam logic [20:0] c_BAOUT    = 21'h1 << 1;
   localparam logic [20:0] c_ADD      = 21'h1;

   localparam logic [20:0] c_F0    = c_PCOUT | c_MARIN | c_INCPC | c_ZLOWIN;
   localparam logic [20:0] c_F1    = c_ZLOWOUT | c_PCIN | c_READ | c_MDREAD | c_MDRIN;
   localparam logic [20:0] c_F1W   = c_ZLOWOUT | c_READ | c_MDREAD | c_MDRIN;
   localparam logic [20:0] c_F2    = c_MDROUT | c_IRIN;
   localparam logic [20:0] c_E0BA  = c_GRB | c_BAOUT | c_YIN;
   localparam logic [20:0] c_E0R   = c_GRB | c_ROUT | c_YIN;
   localparam logic [20:0] c_E1C   = c_CSIGN | c_ADD | c_ZLOWIN;
   localparam logic [20:0] c_E1A   = c_GRC | c_ROUT | c_ADD | c_ZLOWIN;
   localparam logic [20:0] c_E2WB  = c_ZLOWOUT | c_GRA | c_RIN;
   localparam logic [20:0] c_E2MA  = c_ZLOWOUT | c_MARIN;
   localparam logic [20:0] c_E3LD  = c_READ | c_MDREAD | c_MDRIN;
   localparam logic [20:0] c_E3ST  = c_GRA | c_ROUT | c_MDRIN;
   localparam logic [20:0] c_E4LD  = c_MDROUT | c_GRA | c_RIN;
   localparam logic [20:0] c_E4ST  = c_MDROUT | c_WRITE;

   localparam logic [3:0] c_S_HALT = 4'b1000;
   localparam logic [3:0] c_S_DONE = 4'b0100;
   localparam logic [3:0] c_S_ILL  = 4'b0010;
   localparam logic [3:0] c_S_MERR = 4'b0001;

   logic r_clk;
   logic r_clear;
   int   r_checks;
   int   r_fails;
   int   r_pcin_cnt;
   int   r_rin_cnt;
   int   r_wr_cnt;

   control_sequencer_if #(.IR_W(32)) bus ();

   control_sequencer #(
      .IR_W     (32),
      .OPC_W    (5),
      .WAIT_MAX (15)
   ) dut (
      .clock (r_clk),
      .clear (r_clear),
      .bus   (bus.master)
   );

   wire [20:0] w_ctrl = {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin,
                         bus.MDRout, bus.MD_read, bus.Read, bus.Write, bus.IRin,
                         bus.Yin, bus.Zlowin, bus.Zlowout, bus.Csignout, bus.Gra,
                         bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.ADD};
   wire [3:0]  w_stat = {bus.halted, bus.instr_done, bus.illegal, bus.mem_err};

   initial r_clk = 1'b0;
   always #5 r_clk = ~r_clk;

   initial begin
      r_pcin_cnt = 0;
      r_rin_cnt  = 0;
      r_wr_cnt   = 0;
      forever begin
         @(negedge r_clk);
         if (bus.PCin)  r_pcin_cnt = r_pcin_cnt + 1;
         if (bus.Rin)   r_rin_cnt  = r_rin_cnt + 1;
         if (bus.Write) r_wr_cnt   = r_wr_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      r_checks = r_checks + 1;
      if (got !== exp) begin
         r_fails = r_fails + 1;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // One state cycle: inputs already set at posedge+1, compare at posedge+2.
   task automatic cyc(input string tag, input logic [20:0] ce, input logic [3:0] se);
      #1;
      check({tag, " ctrl"}, 32'(w_ctrl), 32'(ce));
      check({tag, " stat"}, 32'(w_stat), 32'(se));
      @(posedge r_clk);
      #1;
   endtask

   task automatic fetch(input int waits);
      cyc("F0", c_F0, 4'b0000);
      for (int i = 0; i < waits; i++) begin
         bus.mem_ready = 1'b0;
         cyc("F1 wait", c_F1W, 4'b0000);
      end
      bus.mem_ready = 1'b1;
      cyc("F1", c_F1, 4'b0000);
      cyc("F2", c_F2, 4'b0000);
   endtask

   initial begin
      int base_pc;
      int base_rin;
      int base_wr;
      r_checks      = 0;
      r_fails       = 0;
      r_clear       = 1'b1;
      bus.run       = 1'b0;
      bus.mem_ready = 1'b1;
      bus.ir        = 32'h0;
      @(posedge r_clk);
      #1;
      bus.run = 1'b1;
      cyc("reset", 21'h0, 4'b0000);
      cyc("reset held", 21'h0, 4'b0000);
      bus.run = 1'b0;
      r_clear = 1'b0;

      // ldi r1, r0, 5
      bus.ir = 32'h0880_0005;
      fetch(0);
      cyc("ldi E0", c_E0BA, 4'b0000);
      cyc("ldi E1", c_E1C, 4'b0000);
      cyc("ldi E2", c_E2WB, c_S_DONE);

      bus.ir = {5'b01100, 27'd3};
      fetch(0);
      cyc("addi E0", c_E0R, 4'b0000);
      cyc("addi E1", c_E1C, 4'b0000);
      cyc("addi E2", c_E2WB, c_S_DONE);

      bus.ir = {5'b00011, 27'h123};
      fetch(0);
      cyc("add E0", c_E0R, 4'b0000);
      cyc("add E1", c_E1A, 4'b0000);
      cyc("add E2", c_E2WB, c_S_DONE);

      // ld with three wait cycles in both F1 and E3
      base_pc = r_pcin_cnt;
      bus.ir  = {5'b00000, 27'h40};
      fetch(3);
      cyc("ld E0", c_E0BA, 4'b0000);
      cyc("ld E1", c_E1C, 4'b0000);
      cyc("ld E2", c_E2MA, 4'b0000);
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc("ld E3 wait", c_E3LD, 4'b0000);
      bus.mem_ready = 1'b1;
      cyc("ld E3", c_E3LD, 4'b0000);
      cyc("ld E4", c_E4LD, c_S_DONE);
      check("ld PCin pulses", 32'(r_pcin_cnt - base_pc), 32'd1);

      bus.ir = {5'b00010, 27'h80};
      fetch(0);
      cyc("st E0", c_E0BA, 4'b0000);
      cyc("st E1", c_E1C, 4'b0000);
      cyc("st E2", c_E2MA, 4'b0000);
      cyc("st E3", c_E3ST, 4'b0000);
      cyc("st E4", c_E4ST, c_S_DONE);

      bus.ir = {5'b11010, 27'h0};
      fetch(0);
      cyc("nop E0", 21'h0, c_S_DONE);

      bus.ir = {5'b11011, 27'h0};
      fetch(0);
      cyc("halt E0", 21'h0, c_S_HALT);
      for (int i = 0; i < 5; i++) cyc("halt idle", 21'h0, c_S_HALT);
      bus.run = 1'b1;
      cyc("halt run", 21'h0, c_S_HALT);
      bus.run = 1'b0;

      base_rin = r_rin_cnt;
      base_wr  = r_wr_cnt;
      bus.ir   = {5'b11111, 27'h0};
      fetch(0);
      cyc("illegal E0", 21'h0, c_S_ILL);
      check("illegal Rin", 32'(r_rin_cnt - base_rin), 32'd0);
      check("illegal Write", 32'(r_wr_cnt - base_wr), 32'd0);

      // st whose write never completes: 15 wait cycles then abandon
      bus.ir = {5'b00010, 27'h84};
      fetch(0);
      cyc("stto E0", c_E0BA, 4'b0000);
      cyc("stto E1", c_E1C, 4'b0000);
      cyc("stto E2", c_E2MA, 4'b0000);
      cyc("stto E3", c_E3ST, 4'b0000);
      base_wr       = r_wr_cnt;
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 14; i++) cyc("stto E4 wait", c_E4ST, 4'b0000);
      cyc("stto E4 timeout", c_E4ST, c_S_MERR);
      check("stto Write cycles", 32'(r_wr_cnt - base_wr), 32'd15);

      // add aborted by clear in E1
      bus.ir   = {5'b00011, 27'h55};
      fetch(4);
      base_rin = r_rin_cnt;
      cyc("abort E0", c_E0R, 4'b0000);
      r_clear = 1'b1;
      cyc("abort E1 clear", 21'h0, 4'b0000);
      cyc("abort clear held", 21'h0, 4'b0000);
      r_clear = 1'b0;
      cyc("abort F0", c_F0, 4'b0000);
      check("abort Rin", 32'(r_rin_cnt - base_rin), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", r_checks, r_fails);
      $finish;
   end

endmodule

`default_nettype wire
